// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS-subset core (add, addi, lw, sw, beq).
// All controls are registered alongside the state and always equal the decode of the state register.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic [3:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_source,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] FN_ADD   = 6'h20;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADDR  = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_REXEC    = 4'd7,
        S_RWB      = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_BRANCH   = 4'd11,
        S_ILLEGAL  = 4'd15
    } state_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    state_t      state_r;
    state_t      nxt_state_s;
    ctrl_t       ctrl_r;
    ctrl_t       nxt_ctrl_s;
    logic        illegal_r;
    logic        retire_s;
    logic [31:0] count_r;
    logic        zero_unused_s;

    // Final states retire an instruction on the edge that leaves them.
    function automatic logic is_final_f(input state_t s);
        logic fin;
        case (s)
            S_MEMWB, S_MEMWRITE, S_RWB, S_ADDIWB, S_BRANCH: fin = 1'b1;
            default:                                         fin = 1'b0;
        endcase
        return fin;
    endfunction

    // Unknown opcodes, unknown R-type functs and corrupt state encodings all end in the trap.
    function automatic state_t next_state_f(input state_t     cur,
                                            input logic       run_i,
                                            input logic [5:0] op,
                                            input logic [5:0] fn);
        state_t nxt;
        case (cur)
            S_IDLE:     nxt = run_i ? S_FETCH : S_IDLE;
            S_FETCH:    nxt = S_DECODE;
            S_DECODE: begin
                if ((op == OP_LW) || (op == OP_SW)) begin
                    nxt = S_MEMADDR;
                end else if ((op == OP_RTYPE) && (fn == FN_ADD)) begin
                    nxt = S_REXEC;
                end else if (op == OP_ADDI) begin
                    nxt = S_ADDIEXEC;
                end else if (op == OP_BEQ) begin
                    nxt = S_BRANCH;
                end else begin
                    nxt = S_ILLEGAL;
                end
            end
            S_MEMADDR: begin
                if (op == OP_LW) begin
                    nxt = S_MEMREAD;
                end else if (op == OP_SW) begin
                    nxt = S_MEMWRITE;
                end else begin
                    nxt = S_ILLEGAL;
                end
            end
            S_MEMREAD:  nxt = S_MEMWB;
            S_REXEC:    nxt = S_RWB;
            S_ADDIEXEC: nxt = S_ADDIWB;
            S_MEMWB, S_MEMWRITE, S_RWB, S_ADDIWB, S_BRANCH:
                        nxt = run_i ? S_FETCH : S_IDLE;
            S_ILLEGAL:  nxt = S_ILLEGAL;
            default:    nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

    // Control word for each state; anything not set stays 0.
    function automatic ctrl_t decode_f(input state_t s);
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_a = 1'b0;
                c.alu_src_b = 2'b01;
                c.pc_source = 2'b00;
            end
            S_DECODE: begin
                // Branch target PC+4+(imm<<2) lands in ALUOut ahead of BRANCH.
                c.alu_src_a = 1'b0;
                c.alu_src_b = 2'b11;
            end
            S_MEMADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_dst    = 1'b0;
            end
            S_MEMWRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_REXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b00;
            end
            S_RWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.mem_to_reg = 1'b0;
            end
            S_ADDIEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b0;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = 2'b00;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            default: begin
                c        = '0;
                c.alu_op = ALU_ADD;
            end
        endcase
        return c;
    endfunction

    // Next state, its control word and the retire strobe for the current cycle.
    always_comb begin
        nxt_state_s = next_state_f(state_r, run, opcode, funct);
        nxt_ctrl_s  = decode_f(nxt_state_s);
        retire_s    = is_final_f(state_r);
    end

    // zero only feeds the datapath's pc_write | (pc_write_cond & zero) gate.
    assign zero_unused_s = zero;

    // State, registered controls, sticky trap flag and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            ctrl_r    <= '0;
            illegal_r <= 1'b0;
            count_r   <= 32'd0;
        end else begin
            state_r   <= nxt_state_s;
            ctrl_r    <= nxt_ctrl_s;
            illegal_r <= illegal_r | (nxt_state_s == S_ILLEGAL);
            if (retire_s) begin
                count_r <= count_r + 32'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign alu_op        = ctrl_r.alu_op;
    assign alu_src_a     = ctrl_r.alu_src_a;
    assign alu_src_b     = ctrl_r.alu_src_b;
    assign pc_source     = ctrl_r.pc_source;
    assign pc_write      = ctrl_r.pc_write;
    assign pc_write_cond = ctrl_r.pc_write_cond;
    assign i_or_d        = ctrl_r.i_or_d;
    assign mem_read      = ctrl_r.mem_read;
    assign mem_write     = ctrl_r.mem_write;
    assign ir_write      = ctrl_r.ir_write;
    assign reg_write     = ctrl_r.reg_write;
    assign reg_dst       = ctrl_r.reg_dst;
    assign mem_to_reg    = ctrl_r.mem_to_reg;
    assign illegal       = illegal_r;
    assign state         = state_r;
    assign instr_count   = count_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed instruction sequences push expected
// state/count per cycle; a negedge monitor pops and checks state, full control word and count.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset, run, zero;
    logic [5:0]  opcode, funct;
    logic [3:0]  alu_op, state;
    logic        alu_src_a;
    logic [1:0]  alu_src_b, pc_source;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic        ir_write, reg_write, reg_dst, mem_to_reg, illegal;
    logic [31:0] instr_count;

    multicycle_control dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;

    localparam logic [31:0] TARGET = 32'h0000_0100;
    logic [31:0] pc_m;

    // Expected control word per state:
    // {alu_op, src_a, src_b, pc_source, pc_write, pc_write_cond, i_or_d, mem_read,
    //  mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal}
    function automatic logic [18:0] exp_ctrl(input logic [3:0] s);
        logic [3:0] op;
        logic       sa, pw, pwc, iod, mr, mw, irw, rw, rd, m2r, ill;
        logic [1:0] sb, ps;
        op = 4'd0; sa = 1'b0; sb = 2'b00; ps = 2'b00;
        pw = 1'b0; pwc = 1'b0; iod = 1'b0; mr = 1'b0; mw = 1'b0;
        irw = 1'b0; rw = 1'b0; rd = 1'b0; m2r = 1'b0; ill = 1'b0;
        case (s)
            4'd1:  begin mr = 1'b1; irw = 1'b1; pw = 1'b1; sb = 2'b01; end
            4'd2:  begin sb = 2'b11; end
            4'd3:  begin sa = 1'b1; sb = 2'b10; end
            4'd4:  begin mr = 1'b1; iod = 1'b1; end
            4'd5:  begin rw = 1'b1; m2r = 1'b1; end
            4'd6:  begin mw = 1'b1; iod = 1'b1; end
            4'd7:  begin sa = 1'b1; end
            4'd8:  begin rw = 1'b1; rd = 1'b1; end
            4'd9:  begin sa = 1'b1; sb = 2'b10; end
            4'd10: begin rw = 1'b1; end
            4'd11: begin sa = 1'b1; op = 4'b0001; pwc = 1'b1; ps = 2'b01; end
            4'd15: begin ill = 1'b1; end
            default: begin end
        endcase
        return {op, sa, sb, ps, pw, pwc, iod, mr, mw, irw, rw, rd, m2r, ill};
    endfunction

    // Small PC model driven by the controls, as the datapath would use them.
    always @(posedge clk) begin
        if (reset)
            pc_m <= 32'h0;
        else if (pc_write)
            pc_m <= pc_m + 32'd4;
        else if (pc_write_cond && zero && (pc_source == 2'b01))
            pc_m <= TARGET;
    end

    // Monitor: one expected entry per cycle, compared away from the active edge.
    always @(negedge clk) begin
        logic [18:0] act_c;
        logic [18:0] want_c;
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            act_c  = {alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond, i_or_d,
                      mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal};
            want_c = exp_ctrl(mon_e.st);
            n_vec++;
            if ((state !== mon_e.st) || (act_c !== want_c) || (instr_count !== mon_e.cnt)) begin
                n_miss++;
                $display("FAIL cycle_vec %0d: state=%0d ctrl=%05h count=%08h, required state=%0d ctrl=%05h count=%08h",
                         n_vec, state, act_c, instr_count, mon_e.st, want_c, mon_e.cnt);
            end
        end
    end

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input logic [3:0] st, input logic [31:0] cnt);
        exp_t e;
        e.st  = st;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [3:0] st, input logic [31:0] cnt);
        wait_edge();
        expect_cyc(st, cnt);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got %08h, required %08h", name, act, want);
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; zero = 1'b0; opcode = 6'h00; funct = 6'h20;
        step(4'd0, 32'd0);
        step(4'd0, 32'd0);

        // add: 0 -> 1 -> 2 -> 7 -> 8 -> 1
        reset = 1'b0; run = 1'b1; opcode = 6'h00; funct = 6'h20;
        step(4'd1, 32'd0); step(4'd2, 32'd0); step(4'd7, 32'd0); step(4'd8, 32'd0);
        step(4'd1, 32'd1);

        // lw then sw, run held high
        opcode = 6'h23;
        step(4'd2, 32'd1); step(4'd3, 32'd1); step(4'd4, 32'd1); step(4'd5, 32'd1);
        step(4'd1, 32'd2);
        opcode = 6'h2B;
        step(4'd2, 32'd2); step(4'd3, 32'd2); step(4'd6, 32'd2);
        step(4'd1, 32'd3);

        // beq taken
        opcode = 6'h04; zero = 1'b1;
        step(4'd2, 32'd3); step(4'd11, 32'd3); step(4'd1, 32'd4);
        check32("beq_taken_pc", pc_m, TARGET);
        // beq not taken: only the fetch increment moves the PC
        zero = 1'b0;
        step(4'd2, 32'd4); step(4'd11, 32'd4); step(4'd1, 32'd5);
        check32("beq_not_taken_pc", pc_m, TARGET + 32'd4);

        // addi with run dropped mid-instruction
        opcode = 6'h08;
        step(4'd2, 32'd5); step(4'd9, 32'd5);
        run = 1'b0;
        step(4'd10, 32'd5); step(4'd0, 32'd6); step(4'd0, 32'd6);
        run = 1'b1;
        step(4'd1, 32'd6);

        // reset while in MEMREAD: no write-back, back to IDLE cleared
        opcode = 6'h23;
        step(4'd2, 32'd6); step(4'd3, 32'd6); step(4'd4, 32'd6);
        reset = 1'b1;
        step(4'd0, 32'd0);
        reset = 1'b0; run = 1'b0;
        step(4'd0, 32'd0);

        // illegal opcode 3F: trap holds regardless of run
        run = 1'b1; opcode = 6'h3F;
        step(4'd1, 32'd0); step(4'd2, 32'd0); step(4'd15, 32'd0);
        for (int i = 0; i < 10; i++) begin
            run = i[0];
            step(4'd15, 32'd0);
        end
        reset = 1'b1;
        step(4'd0, 32'd0);

        // R-type with funct 22 is also illegal
        reset = 1'b0; run = 1'b1; opcode = 6'h00; funct = 6'h22;
        step(4'd1, 32'd0); step(4'd2, 32'd0); step(4'd15, 32'd0);
        step(4'd15, 32'd0); step(4'd15, 32'd0);
        reset = 1'b1;
        step(4'd0, 32'd0);
        reset = 1'b0; run = 1'b0; funct = 6'h20;
        step(4'd0, 32'd0);

        // counter wrap: preload all-ones, retire one add
        wait_edge();
        force dut.count_r = 32'hFFFF_FFFF;
        #1;
        release dut.count_r;
        expect_cyc(4'd0, 32'hFFFF_FFFF);
        run = 1'b1;
        step(4'd1, 32'hFFFF_FFFF); step(4'd2, 32'hFFFF_FFFF);
        step(4'd7, 32'hFFFF_FFFF); step(4'd8, 32'hFFFF_FFFF);
        step(4'd1, 32'd0);
        run = 1'b0;
        step(4'd2, 32'd0); step(4'd7, 32'd0); step(4'd8, 32'd0); step(4'd0, 32'd1);

        wait_edge();
        wait_edge();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
